// File: rtl/vga_timing_if.sv
// Pixel-side bus of the VGA timing generator: coordinates out to the drawing
// stage, RGB565 back, plus the DAC/connector pins and game-logic strobes.
interface vga_timing_if;
  logic [15:0] iRGB;
  logic [9:0]  oVGA_X;
  logic [9:0]  oVGA_Y;
  logic [4:0]  oVGA_R;
  logic [5:0]  oVGA_G;
  logic [4:0]  oVGA_B;
  logic        oVGA_HS;
  logic        oVGA_VS;
  logic        oVGA_BLANK_N;
  logic        oFrame_start;
  logic        oActive;

  modport master (
    input  iRGB,
    output oVGA_X, oVGA_Y, oVGA_R, oVGA_G, oVGA_B,
    output oVGA_HS, oVGA_VS, oVGA_BLANK_N, oFrame_start, oActive
  );

  modport slave (
    output iRGB,
    input  oVGA_X, oVGA_Y, oVGA_R, oVGA_G, oVGA_B,
    input  oVGA_HS, oVGA_VS, oVGA_BLANK_N, oFrame_start, oActive
  );
endinterface

// File: rtl/vga_timing.sv
// 640x480@60 VGA timing generator: pixel/line counters, coordinate outputs,
// sync/blank delayed by the drawing latency, registered DAC pin stage.
module vga_timing #(
  parameter int H_VISIBLE    = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_VISIBLE    = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter int DRAW_LATENCY = 1
) (
  input  logic          iVGA_CLK,
  input  logic          reset,
  vga_timing_if.master  vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEGIN = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEGIN = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0]  h_cnt_r;
  logic [9:0]  v_cnt_r;
  logic        visible_s;
  logic        hs_raw_s;
  logic        vs_raw_s;
  logic [2:0]  raw_s;
  logic [2:0]  dly_s;
  logic [15:0] rgb_r;
  logic        hs_r;
  logic        vs_r;
  logic        blank_n_r;

  // Pixel and line counters; both wrap together at the last pixel of the frame
  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      h_cnt_r <= 10'd0;
      v_cnt_r <= 10'd0;
    end else if (h_cnt_r == H_LAST) begin
      h_cnt_r <= 10'd0;
      if (v_cnt_r == V_LAST) begin
        v_cnt_r <= 10'd0;
      end else begin
        v_cnt_r <= v_cnt_r + 10'd1;
      end
    end else begin
      h_cnt_r <= h_cnt_r + 10'd1;
    end
  end

  // Raw decodes straight from the counters
  always_comb begin
    visible_s = (h_cnt_r < H_VIS) && (v_cnt_r < V_VIS);
    hs_raw_s  = (h_cnt_r >= HS_BEGIN) && (h_cnt_r < HS_END);
    vs_raw_s  = (v_cnt_r >= VS_BEGIN) && (v_cnt_r < VS_END);
    raw_s     = {vs_raw_s, hs_raw_s, visible_s};
  end

  assign vga.oVGA_X       = (h_cnt_r < H_VIS) ? h_cnt_r : 10'd0;
  assign vga.oVGA_Y       = (v_cnt_r < V_VIS) ? v_cnt_r : 10'd0;
  assign vga.oActive      = visible_s;
  assign vga.oFrame_start = ~reset & (h_cnt_r == 10'd0) & (v_cnt_r == 10'd0);

  // Sync/blank travel alongside the drawing stage so they meet its colour
  generate
    if (DRAW_LATENCY == 0) begin : g_no_delay
      assign dly_s = raw_s;
    end else begin : g_delay
      logic [2:0] pipe_r [DRAW_LATENCY];

      // Shift line for {vs, hs, visible}
      always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < DRAW_LATENCY; i++) begin
            pipe_r[i] <= 3'b000;
          end
        end else begin
          pipe_r[0] <= raw_s;
          for (int i = 1; i < DRAW_LATENCY; i++) begin
            pipe_r[i] <= pipe_r[i-1];
          end
        end
      end

      assign dly_s = pipe_r[DRAW_LATENCY-1];
    end
  endgenerate

  // Pin register: colour passes only inside the delayed visible window
  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      rgb_r     <= 16'h0000;
      hs_r      <= 1'b1;
      vs_r      <= 1'b1;
      blank_n_r <= 1'b0;
    end else begin
      rgb_r     <= dly_s[0] ? vga.iRGB : 16'h0000;
      hs_r      <= ~dly_s[1];
      vs_r      <= ~dly_s[2];
      blank_n_r <= dly_s[0];
    end
  end

  assign vga.oVGA_R       = rgb_r[15:11];
  assign vga.oVGA_G       = rgb_r[10:5];
  assign vga.oVGA_B       = rgb_r[4:0];
  assign vga.oVGA_HS      = hs_r;
  assign vga.oVGA_VS      = vs_r;
  assign vga.oVGA_BLANK_N = blank_n_r;

endmodule

// File: tb/tb_vga_timing.sv
// Bench: full-size instance plus two shrunken-geometry instances (latency 1 and 2)
// checked cycle by cycle against a position-from-elapsed-time reference model.
module tb_vga_timing;

  localparam int NI   = 3;
  localparam int HMAX = 4096;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_timing_if bus0 ();
  vga_timing_if bus1 ();
  vga_timing_if bus2 ();

  vga_timing #(.DRAW_LATENCY(1)) dut0 (.iVGA_CLK(clk), .reset(reset), .vga(bus0));

  vga_timing #(.H_VISIBLE(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(5),
               .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
               .DRAW_LATENCY(1)) dut1 (.iVGA_CLK(clk), .reset(reset), .vga(bus1));

  vga_timing #(.H_VISIBLE(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(5),
               .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
               .DRAW_LATENCY(2)) dut2 (.iVGA_CLK(clk), .reset(reset), .vga(bus2));

  // geometry of each instance, mirrored from the parameter overrides above
  int hv [NI], hf [NI], hsw [NI], hb [NI];
  int vv [NI], vf [NI], vsw [NI], vb [NI];
  int lat [NI];

  logic [9:0]  ox [NI], oy [NI];
  logic [4:0]  o_r [NI], o_b [NI];
  logic [5:0]  o_g [NI];
  logic        ohs [NI], ovs [NI], obl [NI], ofs [NI], oact [NI];

  logic [15:0] rgb_drv [NI];
  logic [15:0] rgb_hist [NI][HMAX];
  logic [9:0]  xh [NI][HMAX];
  logic [9:0]  yh [NI][HMAX];
  logic        ah [NI][HMAX];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sample_all();
    ox[0] = bus0.oVGA_X; oy[0] = bus0.oVGA_Y; o_r[0] = bus0.oVGA_R; o_g[0] = bus0.oVGA_G;
    o_b[0] = bus0.oVGA_B; ohs[0] = bus0.oVGA_HS; ovs[0] = bus0.oVGA_VS;
    obl[0] = bus0.oVGA_BLANK_N; ofs[0] = bus0.oFrame_start; oact[0] = bus0.oActive;
    ox[1] = bus1.oVGA_X; oy[1] = bus1.oVGA_Y; o_r[1] = bus1.oVGA_R; o_g[1] = bus1.oVGA_G;
    o_b[1] = bus1.oVGA_B; ohs[1] = bus1.oVGA_HS; ovs[1] = bus1.oVGA_VS;
    obl[1] = bus1.oVGA_BLANK_N; ofs[1] = bus1.oFrame_start; oact[1] = bus1.oActive;
    ox[2] = bus2.oVGA_X; oy[2] = bus2.oVGA_Y; o_r[2] = bus2.oVGA_R; o_g[2] = bus2.oVGA_G;
    o_b[2] = bus2.oVGA_B; ohs[2] = bus2.oVGA_HS; ovs[2] = bus2.oVGA_VS;
    obl[2] = bus2.oVGA_BLANK_N; ofs[2] = bus2.oFrame_start; oact[2] = bus2.oActive;
  endtask

  task automatic drive_all();
    bus0.iRGB = rgb_drv[0];
    bus1.iRGB = rgb_drv[1];
    bus2.iRGB = rgb_drv[2];
  endtask

  // screen position t clocks after reset release, from the line/frame arithmetic
  function automatic void geom(input int k, input int t, output int h, output int v,
                               output bit vis, output bit hsr, output bit vsr);
    int ht, vt;
    ht  = hv[k] + hf[k] + hsw[k] + hb[k];
    vt  = vv[k] + vf[k] + vsw[k] + vb[k];
    h   = t % ht;
    v   = (t / ht) % vt;
    vis = (h < hv[k]) && (v < vv[k]);
    hsr = (h >= hv[k] + hf[k]) && (h < hv[k] + hf[k] + hsw[k]);
    vsr = (v >= vv[k] + vf[k]) && (v < vv[k] + vf[k] + vsw[k]);
  endfunction

  task automatic check_cycle(input int k, input int t);
    int h, v, p, ph, pv;
    bit vis, hsr, vsr, pvis, phs, pvs;
    logic [15:0] rgb_o, rgb_e;
    logic [9:0]  x_dec;
    logic [5:0]  y_dec;
    string s;
    s = $sformatf("i%0d t=%0d", k, t);
    geom(k, t, h, v, vis, hsr, vsr);
    check_val({"x ", s}, ox[k], (h < hv[k]) ? h : 0);
    check_val({"y ", s}, oy[k], (v < vv[k]) ? v : 0);
    check_val({"x_bound ", s}, (ox[k] < hv[k]) ? 1 : 0, 1);
    check_val({"y_bound ", s}, (oy[k] < vv[k]) ? 1 : 0, 1);
    check_val({"active ", s}, oact[k], vis);
    check_val({"frame_start ", s}, ofs[k], (h == 0 && v == 0) ? 1 : 0);

    rgb_o = {o_r[k], o_g[k], o_b[k]};
    p = t - lat[k] - 1;
    if (p < 0) begin
      pvis = 1'b0; phs = 1'b0; pvs = 1'b0; ph = 0; pv = 0;
    end else begin
      geom(k, p, ph, pv, pvis, phs, pvs);
    end
    rgb_e = pvis ? rgb_hist[k][t-1] : 16'h0000;
    check_val({"hs ", s}, ohs[k], !phs);
    check_val({"vs ", s}, ovs[k], !pvs);
    check_val({"blank_n ", s}, obl[k], pvis);
    check_val({"rgb ", s}, rgb_o, rgb_e);
    if (k > 0 && pvis) begin
      x_dec = {rgb_o[4:0], rgb_o[15:11]};
      y_dec = rgb_o[10:5];
      check_val({"align_x ", s}, x_dec, ph);
      check_val({"align_y ", s}, y_dec, pv);
    end
  endtask

  task automatic check_reset(input string tag);
    sample_all();
    for (int k = 0; k < NI; k++) begin
      check_val($sformatf("rst_hs %s i%0d", tag, k), ohs[k], 1);
      check_val($sformatf("rst_vs %s i%0d", tag, k), ovs[k], 1);
      check_val($sformatf("rst_blank_n %s i%0d", tag, k), obl[k], 0);
      check_val($sformatf("rst_rgb %s i%0d", tag, k), {o_r[k], o_g[k], o_b[k]}, 0);
      check_val($sformatf("rst_x %s i%0d", tag, k), ox[k], 0);
      check_val($sformatf("rst_y %s i%0d", tag, k), oy[k], 0);
      check_val($sformatf("rst_active %s i%0d", tag, k), oact[k], 1);
      check_val($sformatf("rst_frame_start %s i%0d", tag, k), ofs[k], 0);
    end
  endtask

  task automatic random_drive();
    for (int k = 0; k < NI; k++) rgb_drv[k] = 16'($urandom);
    drive_all();
  endtask

  initial begin
    int run_len;
    int q;
    logic [9:0] xq, yq;

    for (int k = 0; k < NI; k++) begin
      if (k == 0) begin
        hv[k] = 640; hf[k] = 16; hsw[k] = 96; hb[k] = 48;
        vv[k] = 480; vf[k] = 10; vsw[k] = 2;  vb[k] = 33;
      end else begin
        hv[k] = 20; hf[k] = 4; hsw[k] = 6; hb[k] = 5;
        vv[k] = 12; vf[k] = 2; vsw[k] = 2; vb[k] = 3;
      end
    end
    lat[0] = 1; lat[1] = 1; lat[2] = 2;

    reset = 1'b1;
    random_drive();
    #2;
    check_reset("power_on");
    repeat (3) @(posedge clk);

    for (int ep = 0; ep < 3; ep++) begin
      run_len = (ep == 0) ? 1500 : int'($urandom_range(700, 1500));
      #1 reset = 1'b0;
      #1;
      for (int t = 0; t < run_len; t++) begin
        sample_all();
        for (int k = 0; k < NI; k++) begin
          check_cycle(k, t);
          xh[k][t] = ox[k];
          yh[k][t] = oy[k];
          ah[k][t] = oact[k];
        end
        // full-size instance sees a constant white draw stage
        rgb_drv[0] = 16'hFFFF;
        for (int k = 1; k < NI; k++) begin
          q = t - lat[k];
          if (q >= 0 && ah[k][q]) begin
            xq = xh[k][q];
            yq = yh[k][q];
            rgb_drv[k] = {xq[4:0], yq[5:0], xq[9:5]};
          end else begin
            rgb_drv[k] = 16'($urandom);
          end
        end
        for (int k = 0; k < NI; k++) rgb_hist[k][t] = rgb_drv[k];
        drive_all();
        @(posedge clk);
        #2;
      end
      // asynchronous reset somewhere inside the cycle
      #($urandom_range(1, 6));
      reset = 1'b1;
      #1;
      check_reset($sformatf("mid_ep%0d", ep));
      random_drive();
      repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
